// File: rtl/comperator_pkg.sv
// Shared types and helpers for the stereo line matcher: pixel geometry, cost width,
// FSM encoding and the packed-line pixel extractor.
package comperator_pkg;

    localparam int PIXEL_WIDTH     = 24;
    localparam int CHAN_WIDTH      = 8;
    localparam int COST_WIDTH      = 10;
    localparam int LINE_MAX_PIXELS = 512;
    localparam int LINE_MAX_BITS   = LINE_MAX_PIXELS * PIXEL_WIDTH;
    localparam int LINE_IDX_W      = $clog2(LINE_MAX_BITS);

    // Above the worst real cost (765) so the first evaluated candidate always wins.
    localparam logic [COST_WIDTH-1:0] COST_INIT = 10'd1023;

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LATCH  = 3'd2,
        ST_SEARCH = 3'd3,
        ST_EMIT   = 3'd4
    } state_e;

    // Pixel 0 sits in the MSBs; the line is zero-extended to LINE_MAX_BITS by the caller.
    function automatic logic [PIXEL_WIDTH-1:0] pixel_at(
        input logic [LINE_MAX_BITS-1:0] line,
        input logic [15:0]              width,
        input logic [15:0]              x
    );
        logic [LINE_IDX_W-1:0] lsb;
        lsb = LINE_IDX_W'((32'(width) - 32'(x) - 32'd1) * 32'(PIXEL_WIDTH));
        return line[lsb +: PIXEL_WIDTH];
    endfunction

endpackage

// File: rtl/comperator_axi_ip_v1_0_line_matcher_pixel_sad.sv
// Combinational sum of absolute channel differences between two RGB pixels.
module comperator_axi_ip_v1_0_pixel_sad
    import comperator_pkg::*;
(
    input  logic [PIXEL_WIDTH-1:0] pix_a,
    input  logic [PIXEL_WIDTH-1:0] pix_b,
    output logic [COST_WIDTH-1:0]  cost
);

    function automatic logic [CHAN_WIDTH-1:0] abs_diff(
        input logic [CHAN_WIDTH-1:0] a,
        input logic [CHAN_WIDTH-1:0] b
    );
        if (a >= b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

    // Three 8-bit differences summed in 10 bits: 3*255 = 765 cannot overflow.
    always_comb begin
        cost = COST_WIDTH'(abs_diff(pix_a[23:16], pix_b[23:16]))
             + COST_WIDTH'(abs_diff(pix_a[15:8],  pix_b[15:8]))
             + COST_WIDTH'(abs_diff(pix_a[7:0],   pix_b[7:0]));
    end

endmodule

// File: rtl/comperator_axi_ip_v1_0_line_matcher.sv
// Latches a left/right line pair, searches the best SAD disparity per pixel and
// streams one disparity per pixel over AXI4-Stream while the readers refill.
module comperator_axi_ip_v1_0_line_matcher
    import comperator_pkg::*;
#(
    parameter int FRAME_WIDTH  = 320,
    parameter int FRAME_HEIGHT = 240,
    parameter int MAX_DISP     = 16
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [FRAME_WIDTH*PIXEL_WIDTH-1:0] left_line,
    input  logic                               left_done,
    input  logic [FRAME_WIDTH*PIXEL_WIDTH-1:0] right_line,
    input  logic                               right_done,
    output logic                               go,
    output logic [7:0]                         m_axis_tdata,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               m_axis_tlast,
    output logic                               m_axis_tuser
);

    localparam int LINE_BITS = FRAME_WIDTH * PIXEL_WIDTH;
    localparam int XW = $clog2(FRAME_WIDTH + 1);
    localparam int DW = $clog2(MAX_DISP + 1);
    localparam int YW = $clog2(FRAME_HEIGHT + 1);
    localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
    localparam logic [DW-1:0] D_LAST = DW'(MAX_DISP - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);

    state_e                  state_q, state_d;
    logic                    go_q, go_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic                    tuser_q, tuser_d;
    logic [7:0]              tdata_q, tdata_d;
    logic [XW-1:0]           x_q, x_d;
    logic [DW-1:0]           d_q, d_d;
    logic [YW-1:0]           y_q, y_d;
    logic [COST_WIDTH-1:0]   best_cost_q, best_cost_d;
    logic [DW-1:0]           best_d_q, best_d_d;
    logic [LINE_BITS-1:0]    left_line_q, left_line_d;
    logic [LINE_BITS-1:0]    right_line_q, right_line_d;

    logic                    cand_ok_s;
    logic [15:0]             right_x_s;
    logic [PIXEL_WIDTH-1:0]  left_pix_s, right_pix_s;
    logic [COST_WIDTH-1:0]   cost_s;
    logic                    better_s;
    logic [DW-1:0]           best_sel_s;

    // Candidate pixel selection; candidates reaching left of pixel 0 are skipped.
    always_comb begin
        cand_ok_s   = (16'(x_q) >= 16'(d_q));
        right_x_s   = cand_ok_s ? (16'(x_q) - 16'(d_q)) : 16'd0;
        left_pix_s  = pixel_at(LINE_MAX_BITS'(left_line_q), 16'(FRAME_WIDTH), 16'(x_q));
        right_pix_s = pixel_at(LINE_MAX_BITS'(right_line_q), 16'(FRAME_WIDTH), right_x_s);
    end

    comperator_axi_ip_v1_0_pixel_sad u_sad (
        .pix_a (left_pix_s),
        .pix_b (right_pix_s),
        .cost  (cost_s)
    );

    // Next-state logic for the FSM, counters, latched lines and stream outputs.
    always_comb begin
        state_d      = state_q;
        go_d         = 1'b0;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        tdata_d      = tdata_q;
        x_d          = x_q;
        d_d          = d_q;
        y_d          = y_q;
        best_cost_d  = best_cost_q;
        best_d_d     = best_d_q;
        left_line_d  = left_line_q;
        right_line_d = right_line_q;
        better_s     = cand_ok_s && (cost_s < best_cost_q);
        best_sel_s   = best_d_q;

        case (state_q)
            ST_START: begin
                go_d    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (left_done && right_done) begin
                    state_d = ST_LATCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LATCH: begin
                left_line_d  = left_line;
                right_line_d = right_line;
                go_d         = 1'b1;
                x_d          = {XW{1'b0}};
                d_d          = {DW{1'b0}};
                best_cost_d  = COST_INIT;
                best_d_d     = {DW{1'b0}};
                state_d      = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (better_s) begin
                    best_cost_d = cost_s;
                    best_d_d    = d_q;
                    best_sel_s  = d_q;
                end else begin
                    best_sel_s  = best_d_q;
                end
                if (d_q == D_LAST) begin
                    tvalid_d = 1'b1;
                    tdata_d  = 8'(best_sel_s);
                    tlast_d  = (x_q == X_LAST);
                    tuser_d  = (x_q == {XW{1'b0}}) && (y_q == {YW{1'b0}});
                    state_d  = ST_EMIT;
                end else begin
                    d_d = d_q + DW'(1);
                end
            end
            ST_EMIT: begin
                if (tvalid_q && m_axis_tready) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    tuser_d  = 1'b0;
                    if (x_q == X_LAST) begin
                        y_d     = (y_q == Y_LAST) ? {YW{1'b0}} : (y_q + YW'(1));
                        state_d = ST_IDLE;
                    end else begin
                        x_d         = x_q + XW'(1);
                        d_d         = {DW{1'b0}};
                        best_cost_d = COST_INIT;
                        best_d_d    = {DW{1'b0}};
                        state_d     = ST_SEARCH;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                tvalid_d = 1'b0;
                state_d  = ST_START;
            end
        endcase
    end

    // State and output registers; reset drops any line in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_START;
            go_q         <= 1'b0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            tdata_q      <= 8'd0;
            x_q          <= {XW{1'b0}};
            d_q          <= {DW{1'b0}};
            y_q          <= {YW{1'b0}};
            best_cost_q  <= COST_INIT;
            best_d_q     <= {DW{1'b0}};
            left_line_q  <= {LINE_BITS{1'b0}};
            right_line_q <= {LINE_BITS{1'b0}};
        end else begin
            state_q      <= state_d;
            go_q         <= go_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            tdata_q      <= tdata_d;
            x_q          <= x_d;
            d_q          <= d_d;
            y_q          <= y_d;
            best_cost_q  <= best_cost_d;
            best_d_q     <= best_d_d;
            left_line_q  <= left_line_d;
            right_line_q <= right_line_d;
        end
    end

    assign go            = go_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_comperator_axi_ip_v1_0_line_matcher.sv
// Directed bench for the line matcher: 8-pixel lines, 4 disparities, 2-line frames.
module tb_comperator_axi_ip_v1_0_line_matcher;

    localparam int FW = 8;
    localparam int FH = 2;
    localparam int MD = 4;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [FW*24-1:0]  left_line, right_line;
    logic              left_done, right_done;
    logic              go;
    logic [7:0]        tdata;
    logic              tvalid, tready, tlast, tuser;

    int                n_cmp = 0;
    int                n_bad = 0;
    int                line_no = 0;
    logic [23:0]       lp [FW];
    logic [23:0]       rp [FW];
    logic [7:0]        exp_d [FW];

    always #5 aclk = ~aclk;

    comperator_axi_ip_v1_0_line_matcher #(
        .FRAME_WIDTH  (FW),
        .FRAME_HEIGHT (FH),
        .MAX_DISP     (MD)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .left_line     (left_line),
        .left_done     (left_done),
        .right_line    (right_line),
        .right_done    (right_done),
        .go            (go),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .m_axis_tuser  (tuser)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [FW*24-1:0] pack_line(input logic [23:0] px [FW]);
        logic [FW*24-1:0] r;
        r = '0;
        for (int i = 0; i < FW; i++) r[(FW-i)*24-1 -: 24] = px[i];
        return r;
    endfunction

    // Presents lp/rp as a completed pair, plays the reader handshake and checks every beat.
    task automatic run_line(input bit rnd_ready, input int skew);
        int          gos, beats, cyc;
        bit          stalled;
        logic [9:0]  held;
        gos = 0; beats = 0; cyc = 0; stalled = 1'b0; held = '0;
        left_line  = pack_line(lp);
        right_line = pack_line(rp);
        left_done  = 1'b1;
        if (skew > 0) begin
            for (int i = 0; i < skew; i++) begin
                @(negedge aclk);
                if (go) gos++;
            end
            check_val("skew_go", gos, 0);
            check_val("skew_tvalid", tvalid, 0);
        end
        right_done = 1'b1;
        while (beats < FW && cyc < 500) begin
            @(negedge aclk);
            cyc++;
            if (go) begin
                gos++;
                left_done  = 1'b0;
                right_done = 1'b0;
            end
            if (stalled) check_val("stall_hold", {tvalid, tdata, tlast, tuser}, {1'b1, held});
            tready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (tvalid && tready) begin
                check_val($sformatf("tdata_l%0d_x%0d", line_no, beats), tdata, exp_d[beats]);
                check_val($sformatf("tlast_x%0d", beats), tlast, (beats == FW-1));
                check_val($sformatf("tuser_l%0d_x%0d", line_no, beats), tuser,
                          (beats == 0 && line_no == 0));
                beats++;
            end
            stalled = tvalid && !tready;
            held    = {tdata, tlast, tuser};
        end
        if (beats < FW) check_val("line_timeout", beats, FW);
        check_val("go_per_line", gos, 1);
        line_no = (line_no + 1) % FH;
    endtask

    // Releases reset at a falling edge and expects a single go in the first cycle.
    task automatic release_reset();
        int gos;
        bit first_go, seen_valid;
        gos = 0; first_go = 1'b0; seen_valid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        line_no = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            if (i == 0) first_go = go;
            if (go) gos++;
            if (tvalid) seen_valid = 1'b1;
        end
        check_val("go_cycle1", first_go, 1);
        check_val("go_count_after_reset", gos, 1);
        check_val("tvalid_without_done", seen_valid, 0);
    endtask

    task automatic set_shift_pattern();
        for (int i = 0; i < FW; i++) begin
            lp[i] = {3{8'(16*i + 16)}};
            rp[i] = {3{8'(16*(i+2) + 16)}};
        end
        exp_d = '{8'd0, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2};
    endtask

    initial begin
        int waited;
        aresetn    = 1'b0;
        left_done  = 1'b0;
        right_done = 1'b0;
        tready     = 1'b1;
        left_line  = '0;
        right_line = '0;
        repeat (3) @(negedge aclk);
        check_val("reset_outputs", {go, tvalid, tlast, tuser, tdata}, 32'd0);
        release_reset();

        // Right line is the left line shifted by two pixels.
        set_shift_pattern();
        run_line(1'b0, 0);

        // Uniform grey: every candidate ties at cost 0, smallest disparity wins.
        for (int i = 0; i < FW; i++) begin lp[i] = 24'h808080; rp[i] = 24'h808080; exp_d[i] = 8'd0; end
        run_line(1'b0, 0);

        // Full-scale mismatch everywhere: cost 765 must still beat the initial cost.
        for (int i = 0; i < FW; i++) begin lp[i] = 24'hFFFFFF; rp[i] = 24'h000000; exp_d[i] = 8'd0; end
        run_line(1'b0, 0);

        // Single white right pixel at 4: matched by x=4..7 at d=0..3.
        rp[4] = 24'hFFFFFF;
        exp_d = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3};
        run_line(1'b0, 0);

        // Back-pressure: same results as the free-running shift run.
        set_shift_pattern();
        run_line(1'b1, 0);

        // Left done 20 cycles ahead of right.
        for (int i = 0; i < FW; i++) begin lp[i] = 24'h808080; rp[i] = 24'h808080; exp_d[i] = 8'd0; end
        run_line(1'b0, 20);

        // Reset in the middle of a search.
        set_shift_pattern();
        left_line  = pack_line(lp);
        right_line = pack_line(rp);
        left_done  = 1'b1;
        right_done = 1'b1;
        waited = 0;
        while (!go && waited < 50) begin @(negedge aclk); waited++; end
        check_val("mid_go_seen", go, 1);
        left_done  = 1'b0;
        right_done = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check_val("mid_reset_outputs", {go, tvalid, tlast, tuser, tdata}, 32'd0);
        release_reset();
        run_line(1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
